lut_neuron_loader: RTL

- Run-time programmable truth-table neuron; the write side of the fixed per-neuron ROM layer blocks.
- Accepts a truth table as a stream of config beats and stores it in a 2^IN_BITS x OUT_BITS distributed RAM.
- Once loaded, serves registered lookups with the same input-to-output mapping a generated neuron ROM would give.
- Used for in-field retraining and for bring-up of layer LUTs without resynthesis.

---
 rtl/lut_neuron_loader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/lut_neuron_loader.sv
// Run-time loadable truth-table neuron: streams a 2^IN_BITS x OUT_BITS table in
// LOAD_W-bit beats, then serves registered lookups. Define LUT_PARITY_EN to require a trailing parity beat.
module lut_neuron_loader #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1,
  parameter int LOAD_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [LOAD_W-1:0]   cfg_data,
  input  logic                cfg_last,
  output logic                load_done,
  output logic                load_err,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data
);

  localparam int DEPTH = 1 << IN_BITS;
  localparam int TBITS = DEPTH * OUT_BITS;
  localparam int NB    = TBITS / LOAD_W;
  localparam int CW    = $clog2(NB) + 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [CW-1:0]     cnt_r;
  logic [TBITS-1:0]  table_r;
  logic              xfer_s;
  logic              data_beat_s;
  logic              ready_s;
  logic              done_s;
  logic              err_s;
  logic              cfg_ready_r;
  logic              load_done_r;
  logic              load_err_r;
  logic              out_valid_r;
  logic [OUT_BITS-1:0] out_data_r;

  // cfg_start wins over a coincident beat, so that beat never transfers
  assign xfer_s      = cfg_valid && (state_r == ST_LOAD) && !cfg_start;
  assign data_beat_s = xfer_s && (cnt_r < CW'(NB));

`ifdef LUT_PARITY_EN
  logic par_r;

  function automatic logic beat_parity(input logic [LOAD_W-1:0] d);
    return ^d;
  endfunction

  // Running XOR of every table bit received in the current load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_r <= 1'b0;
    end else if (cfg_start) begin
      par_r <= 1'b0;
    end else if (data_beat_s) begin
      par_r <= par_r ^ beat_parity(cfg_data);
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic including beat framing checks
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (cfg_start) state_s = ST_LOAD;
        else           state_s = ST_EMPTY;
      end
      ST_LOAD: begin
        if (cfg_start) begin
          state_s = ST_LOAD;
        end else if (xfer_s) begin
`ifdef LUT_PARITY_EN
          if (cnt_r == CW'(NB))
            state_s = (cfg_last && (cfg_data[0] == par_r)) ? ST_READY : ST_ERR;
          else if (cfg_last)
            state_s = ST_ERR;
          else
            state_s = ST_LOAD;
`else
          if (cnt_r == CW'(NB - 1))
            state_s = cfg_last ? ST_READY : ST_ERR;
          else if (cfg_last)
            state_s = ST_ERR;
          else
            state_s = ST_LOAD;
`endif
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_READY: begin
        if (cfg_start) state_s = ST_LOAD;
        else           state_s = ST_READY;
      end
      ST_ERR: begin
        if (cfg_start) state_s = ST_LOAD;
        else           state_s = ST_ERR;
      end
      default: state_s = ST_EMPTY;
    endcase
  end

  // Status decode from the upcoming state so the registered flags align with it
  always_comb begin
    ready_s = 1'b0;
    done_s  = 1'b0;
    err_s   = 1'b0;
    case (state_s)
      ST_EMPTY: begin
        ready_s = 1'b0;
      end
      ST_LOAD: begin
        ready_s = 1'b1;
      end
      ST_READY: begin
        done_s = 1'b1;
      end
      ST_ERR: begin
        err_s = 1'b1;
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase
  end

  // Registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready_r <= 1'b0;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      cfg_ready_r <= ready_s;
      load_done_r <= done_s;
      load_err_r  <= err_s;
    end
  end

  // Beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (cfg_start) begin
      cnt_r <= {CW{1'b0}};
    end else if (xfer_s) begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Table storage; intentionally not reset, validity is tracked by the FSM
  always_ff @(posedge clk) begin
    if (data_beat_s) begin
      table_r[int'(cnt_r) * LOAD_W +: LOAD_W] <= cfg_data;
    end
  end

  // Registered lookup port; out_data keeps its last value when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_BITS{1'b0}};
    end else if ((state_r == ST_READY) && in_valid) begin
      out_valid_r <= 1'b1;
      out_data_r  <= table_r[int'(in_data) * OUT_BITS +: OUT_BITS];
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign cfg_ready = cfg_ready_r;
  assign load_done = load_done_r;
  assign load_err  = load_err_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule
